// File: rtl/rc4_pkg.sv
// Shared RC4 definitions: byte type, S-memory depth and the PRGA state encoding.
package rc4_pkg;

  localparam int S_DEPTH = 256;

  typedef logic [7:0] byte_t;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    RD_SI   = 4'd1,
    CALC_J  = 4'd2,
    RD_SJ   = 4'd3,
    WR_SI   = 4'd4,
    WR_SJ   = 4'd5,
    RD_F    = 4'd6,
    RD_E    = 4'd7,
    XOR_CHK = 4'd8,
    WR_D    = 4'd9,
    NEXT    = 4'd10,
    DONE    = 4'd11
  } state_t;

endpackage

// File: rtl/rc4_char_check.sv
// Combinational plaintext acceptance test: a byte passes if it lies in
// [CHAR_LO, CHAR_HI], or if spaces are allowed and it is 8'd32.
module rc4_char_check
  import rc4_pkg::*;
#(
  parameter byte_t CHAR_LO     = 8'd97,
  parameter byte_t CHAR_HI     = 8'd122,
  parameter bit    ALLOW_SPACE = 1'b1
) (
  input  byte_t data,
  output logic  ok
);

  // Range test plus optional space acceptance.
  always_comb begin
    ok = ((data >= CHAR_LO) && (data <= CHAR_HI)) ||
         (ALLOW_SPACE && (data == 8'd32));
  end

endmodule

// File: rtl/rc4_prga_engine.sv
// RC4 PRGA keystream-and-decrypt engine. Walks the shared S-memory, reads
// ciphertext from the encrypted ROM, XORs with the keystream and writes the
// plaintext to the decrypted RAM, with optional character checking and abort.
//
// Memory handshake (all three memories): a *_req output is a one-cycle pulse
// issued in the first cycle of a state; address and write data are held from
// that cycle until the matching *_done is sampled high, and the FSM waits in
// the state until then. A *_done is only meaningful in the state that issued
// the request; strobes seen in any other state are ignored.
module rc4_prga_engine
  import rc4_pkg::*;
#(
  parameter int    MSG_LEN     = 32,
  parameter int    MSG_AW      = $clog2(MSG_LEN),
  parameter byte_t CHAR_LO     = 8'd97,
  parameter byte_t CHAR_HI     = 8'd122,
  parameter bit    ALLOW_SPACE = 1'b1
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              start,
  input  logic              abort,
  input  logic [MSG_AW:0]   msg_len,
  input  logic              check_en,
  output logic              busy,
  output logic              done,
  output logic              msg_valid,
  output logic              msg_invalid,
  output logic              aborted,
  output logic [MSG_AW-1:0] bad_idx,
  output byte_t             s_addr,
  output byte_t             s_wdata,
  output logic              s_rd_req,
  output logic              s_wr_req,
  input  byte_t             s_rdata,
  input  logic              s_rd_done,
  input  logic              s_wr_done,
  output logic              e_rd_req,
  output logic [MSG_AW-1:0] e_addr,
  input  byte_t             e_rdata,
  input  logic              e_rd_done,
  output logic              d_wr_req,
  output logic [MSG_AW-1:0] d_addr,
  output byte_t             d_wdata,
  input  logic              d_wr_done,
  output state_t            fsm_state
);

  localparam logic [MSG_AW:0] MAX_LEN = (MSG_AW+1)'(MSG_LEN);

  state_t            state;
  byte_t             i, j, si, sj, f, ev, p;
  logic [MSG_AW-1:0] k;
  logic [MSG_AW:0]   len, eff_len;
  logic              chk, ok, last;

  assign fsm_state = state;
  assign p         = f ^ ev;
  assign last      = ({1'b0, k} == (len - 1'b1));

  // Out-of-range lengths (0 or above the buffer size) mean a full buffer.
  always_comb begin
    eff_len = msg_len;
    if ((msg_len == '0) || (msg_len > MAX_LEN)) eff_len = MAX_LEN;
  end

  rc4_char_check #(
    .CHAR_LO    (CHAR_LO),
    .CHAR_HI    (CHAR_HI),
    .ALLOW_SPACE(ALLOW_SPACE)
  ) u_char_check (
    .data(p),
    .ok  (ok)
  );

  // Main FSM: sequences the S swap, keystream lookup, XOR/check and RAM write.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state       <= IDLE;
      i           <= '0;
      j           <= '0;
      k           <= '0;
      len         <= '0;
      chk         <= 1'b0;
      si          <= '0;
      sj          <= '0;
      f           <= '0;
      ev          <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      msg_valid   <= 1'b0;
      msg_invalid <= 1'b0;
      aborted     <= 1'b0;
      bad_idx     <= '0;
      s_addr      <= '0;
      s_wdata     <= '0;
      s_rd_req    <= 1'b0;
      s_wr_req    <= 1'b0;
      e_rd_req    <= 1'b0;
      e_addr      <= '0;
      d_wr_req    <= 1'b0;
      d_addr      <= '0;
      d_wdata     <= '0;
    end else begin
      // Requests and done are single-cycle pulses unless re-issued below.
      s_rd_req <= 1'b0;
      s_wr_req <= 1'b0;
      e_rd_req <= 1'b0;
      d_wr_req <= 1'b0;
      done     <= 1'b0;
      if (abort && (state != IDLE) && (state != DONE)) begin
        // Abort takes priority over any completion seen this cycle.
        state   <= DONE;
        done    <= 1'b1;
        aborted <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              len         <= eff_len;
              chk         <= check_en;
              i           <= 8'd1;
              j           <= '0;
              k           <= '0;
              msg_valid   <= 1'b0;
              msg_invalid <= 1'b0;
              aborted     <= 1'b0;
              bad_idx     <= '0;
              busy        <= 1'b1;
              s_addr      <= 8'd1;
              s_rd_req    <= 1'b1;
              state       <= RD_SI;
            end
          end
          RD_SI: begin
            if (s_rd_done) begin
              si    <= s_rdata;
              state <= CALC_J;
            end
          end
          CALC_J: begin
            j        <= j + si;
            s_addr   <= j + si;
            s_rd_req <= 1'b1;
            state    <= RD_SJ;
          end
          RD_SJ: begin
            if (s_rd_done) begin
              sj       <= s_rdata;
              s_addr   <= i;
              s_wdata  <= s_rdata;
              s_wr_req <= 1'b1;
              state    <= WR_SI;
            end
          end
          WR_SI: begin
            if (s_wr_done) begin
              s_addr   <= j;
              s_wdata  <= si;
              s_wr_req <= 1'b1;
              state    <= WR_SJ;
            end
          end
          WR_SJ: begin
            if (s_wr_done) begin
              s_addr   <= si + sj;
              s_rd_req <= 1'b1;
              state    <= RD_F;
            end
          end
          RD_F: begin
            if (s_rd_done) begin
              f        <= s_rdata;
              e_addr   <= k;
              e_rd_req <= 1'b1;
              state    <= RD_E;
            end
          end
          RD_E: begin
            if (e_rd_done) begin
              ev    <= e_rdata;
              state <= XOR_CHK;
            end
          end
          XOR_CHK: begin
            if (chk && !ok) begin
              // Rejected byte is never written to the RAM.
              msg_invalid <= 1'b1;
              bad_idx     <= k;
              done        <= 1'b1;
              state       <= DONE;
            end else begin
              d_addr   <= k;
              d_wdata  <= p;
              d_wr_req <= 1'b1;
              state    <= WR_D;
            end
          end
          WR_D: begin
            if (d_wr_done) state <= NEXT;
          end
          NEXT: begin
            if (last) begin
              msg_valid <= 1'b1;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              k        <= k + 1'b1;
              i        <= i + 8'd1;
              s_addr   <= i + 8'd1;
              s_rd_req <= 1'b1;
              state    <= RD_SI;
            end
          end
          DONE: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rc4_prga_engine.sv
// Bench for rc4_prga_engine: 1-cycle memory models, an RC4 reference model,
// and a monitor that scores RAM writes, run outcomes and posted checks.
module tb_rc4_prga_engine;
  import rc4_pkg::*;

  localparam int MSG_LEN = 32;
  localparam int MSG_AW  = 5;

  typedef struct {
    string       name;
    logic [31:0] got;
    logic [31:0] exp;
  } chk_t;

  // ---------------- clock / reset / DUT signals ----------------
  logic clk = 1'b0, nreset = 1'b0, start = 1'b0, abort = 1'b0, check_en = 1'b0;
  logic [MSG_AW:0] msg_len = '0;
  logic busy, done, msg_valid, msg_invalid, aborted;
  logic [MSG_AW-1:0] bad_idx, e_addr, d_addr;
  byte_t s_addr, s_wdata, d_wdata;
  logic s_rd_req, s_wr_req, e_rd_req, d_wr_req;
  byte_t s_rdata = 8'h00, e_rdata = 8'h00;
  logic s_rd_done = 1'b0, s_wr_done = 1'b0, e_rd_done = 1'b0, d_wr_done = 1'b0;
  state_t fsm_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  rc4_prga_engine dut (
    .clk(clk), .nreset(nreset), .start(start), .abort(abort),
    .msg_len(msg_len), .check_en(check_en), .busy(busy), .done(done),
    .msg_valid(msg_valid), .msg_invalid(msg_invalid), .aborted(aborted),
    .bad_idx(bad_idx), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rd_req(s_rd_req), .s_wr_req(s_wr_req), .s_rdata(s_rdata),
    .s_rd_done(s_rd_done), .s_wr_done(s_wr_done), .e_rd_req(e_rd_req),
    .e_addr(e_addr), .e_rdata(e_rdata), .e_rd_done(e_rd_done),
    .d_wr_req(d_wr_req), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wr_done(d_wr_done), .fsm_state(fsm_state)
  );

  // ---------------- memory models (1-cycle) ----------------
  byte_t s_mem[S_DEPTH];
  byte_t s_init[S_DEPTH];
  byte_t e_rom[MSG_LEN];
  byte_t d_ram[MSG_LEN];
  logic  load_s = 1'b0;
  logic  stray_rd = 1'b0;

  always @(posedge clk) begin
    s_rd_done <= 1'b0;
    s_wr_done <= 1'b0;
    e_rd_done <= 1'b0;
    d_wr_done <= 1'b0;
    if (load_s) begin
      for (int n = 0; n < S_DEPTH; n++) s_mem[n] = s_init[n];
      for (int n = 0; n < MSG_LEN; n++) d_ram[n] = 8'h00;
    end
    if (s_rd_req) begin s_rdata <= s_mem[s_addr]; s_rd_done <= 1'b1; end
    if (s_wr_req) begin s_mem[s_addr] = s_wdata; s_wr_done <= 1'b1; end
    if (e_rd_req) begin e_rdata <= e_rom[e_addr]; e_rd_done <= 1'b1; end
    if (d_wr_req) begin d_ram[d_addr] = d_wdata; d_wr_done <= 1'b1; end
    if (stray_rd) s_rd_done <= 1'b1;
  end

  // ---------------- scoreboard ----------------
  logic [12:0] d_q[$];     // {addr, data}
  logic [23:0] done_q[$];  // {cycles after start, valid, invalid, aborted, bad_idx}
  chk_t        chk_q[$];
  int tests = 0, fails = 0, done_seen = 0, start_cyc = 0;

  task automatic post(input string name, input logic [31:0] got, input logic [31:0] exp);
    chk_t c;
    c.name = name; c.got = got; c.exp = exp;
    chk_q.push_back(c);
  endtask

  // Monitor: scores every DUT write / done pulse and every posted check.
  always @(negedge clk) begin
    chk_t c;
    logic [12:0] de;
    logic [23:0] oe, og;
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      tests++;
      if (c.got !== c.exp) begin
        fails++;
        $display("FAIL %s: got %h, required %h", c.name, c.got, c.exp);
      end
    end
    if (nreset && d_wr_req) begin
      tests++;
      if (d_q.size() == 0) begin
        fails++;
        $display("FAIL d_write: got addr %0d data %h, required no write", d_addr, d_wdata);
      end else begin
        de = d_q.pop_front();
        if ({d_addr, d_wdata} !== de) begin
          fails++;
          $display("FAIL d_write: got addr %0d data %h, required addr %0d data %h",
                   d_addr, d_wdata, de[12:8], de[7:0]);
        end
      end
    end
    if (nreset && done) begin
      done_seen++;
      tests++;
      og = {16'(cyc - start_cyc), msg_valid, msg_invalid, aborted, bad_idx};
      if (done_q.size() == 0) begin
        fails++;
        $display("FAIL done: got %h, required no done", og);
      end else begin
        oe = done_q.pop_front();
        if (og !== oe) begin
          fails++;
          $display("FAIL done: got T%0d v%b i%b a%b idx%0d, required T%0d v%b i%b a%b idx%0d",
                   og[23:8], og[7], og[6], og[5], og[4:0], oe[23:8], oe[7], oe[6], oe[5], oe[4:0]);
        end
      end
    end
  end

  // ---------------- reference model ----------------
  byte_t ks_arr[MSG_LEN];
  byte_t fin_s[S_DEPTH];
  byte_t exp_s[S_DEPTH];

  function automatic bit char_ok(input byte_t p);
    return ((p >= 8'd97) && (p <= 8'd122)) || (p == 8'd32);
  endfunction

  // Textbook RC4 PRGA for n bytes starting from the current S contents.
  task automatic gen_ks(input int n);
    int ii, jj, t;
    byte_t tmp;
    fin_s = s_mem;
    ii = 0; jj = 0;
    for (int kk = 0; kk < n; kk++) begin
      ii = (ii + 1) % 256;
      jj = (jj + int'(fin_s[ii])) % 256;
      tmp = fin_s[ii]; fin_s[ii] = fin_s[jj]; fin_s[jj] = tmp;
      t = (int'(fin_s[ii]) + int'(fin_s[jj])) % 256;
      ks_arr[kk] = fin_s[t];
    end
  endtask

  task automatic predict(input int len_in, input bit chk);
    int L, stop;
    byte_t p;
    L = ((len_in == 0) || (len_in > MSG_LEN)) ? MSG_LEN : len_in;
    gen_ks(L);
    stop = L;
    for (int kk = 0; kk < L; kk++) begin
      p = ks_arr[kk] ^ e_rom[kk];
      if (chk && !char_ok(p)) begin
        stop = kk;
        break;
      end
      d_q.push_back({5'(kk), p});
    end
    if (stop < L) begin
      done_q.push_back({16'(17 * stop + 15), 3'b010, 5'(stop)});
      gen_ks(stop + 1);
    end else begin
      done_q.push_back({16'(17 * L + 1), 3'b100, 5'd0});
    end
    exp_s = fin_s;
  endtask

  // ---------------- driver tasks ----------------
  task automatic load_s_mem();
    @(negedge clk) load_s = 1'b1;
    @(negedge clk) load_s = 1'b0;
  endtask

  task automatic set_identity();
    for (int n = 0; n < S_DEPTH; n++) s_init[n] = 8'(n);
    load_s_mem();
  endtask

  task automatic rand_perm();
    int r;
    byte_t tmp;
    for (int n = 0; n < S_DEPTH; n++) s_init[n] = 8'(n);
    for (int n = S_DEPTH - 1; n > 0; n--) begin
      r = int'($urandom_range(n, 0));
      tmp = s_init[n]; s_init[n] = s_init[r]; s_init[r] = tmp;
    end
    load_s_mem();
  endtask

  // Ciphertext whose plaintext is letters/spaces, optionally one bad byte.
  task automatic craft_e(input int L, input int bad_at);
    byte_t pt;
    gen_ks(L);
    for (int kk = 0; kk < L; kk++) begin
      if (kk == bad_at) pt = 8'($urandom_range(255, 123));
      else if ($urandom_range(4, 0) == 0) pt = 8'd32;
      else pt = 8'($urandom_range(122, 97));
      e_rom[kk] = ks_arr[kk] ^ pt;
    end
  endtask

  // Issue start at T0; returns at the negedge of T1.
  task automatic issue(input int len, input bit chk);
    @(negedge clk);
    start = 1'b1; msg_len = 6'(len); check_en = chk; start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run(input int len, input bit chk);
    predict(len, chk);
    issue(len, chk);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    int seen = done_seen;
    while ((done_seen == seen) && (n < 2000)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) post({name, "_timeout"}, 32'd1, 32'd0);
    @(negedge clk);
    post({name, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  task automatic check_s(input string name);
    int bad = 0;
    for (int n = 0; n < S_DEPTH; n++) if (s_mem[n] !== exp_s[n]) bad++;
    post(name, 32'(bad), 32'd0);
  endtask

  task automatic check_outputs_zero(input string name);
    post({name, "_ctrl"}, 32'({busy, done, msg_valid, msg_invalid, aborted, bad_idx,
                               s_rd_req, s_wr_req, e_rd_req, d_wr_req, d_wdata}), 32'd0);
    post({name, "_addr"}, 32'({s_addr, s_wdata, e_addr, d_addr}), 32'd0);
    post({name, "_state"}, 32'(fsm_state), 32'(IDLE));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int L, mode;
    bit chk;
    for (int n = 0; n < MSG_LEN; n++) e_rom[n] = 8'h00;
    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    set_identity();
    nreset = 1'b1;

    // Two-byte identity-S message decoding to "a ".
    e_rom[0] = 8'h63; e_rom[1] = 8'h25;
    run(2, 1'b1);
    wait_done("ident2");
    check_s("ident2_s");
    post("ident2_d0", 32'(d_ram[0]), 32'h61);
    post("ident2_d1", 32'(d_ram[1]), 32'h20);
    post("ident2_s2", 32'(s_mem[2]), 32'd3);
    post("ident2_s3", 32'(s_mem[3]), 32'd2);
    post("ident2_valid", 32'(msg_valid), 32'd1);

    // Rejected first byte, then the same byte with the check disabled.
    set_identity();
    e_rom[0] = 8'h00;
    run(1, 1'b1);
    wait_done("reject0");
    post("reject0_invalid", 32'(msg_invalid), 32'd1);
    post("reject0_d0", 32'(d_ram[0]), 32'h00);
    set_identity();
    run(1, 1'b0);
    wait_done("nochk");
    post("nochk_d0", 32'(d_ram[0]), 32'h02);

    // Abort during RD_SJ of byte 0; a late read strobe must be ignored.
    set_identity();
    done_q.push_back({16'd5, 3'b001, 5'd0});
    issue(2, 1'b1);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    post("abort_reqs", 32'({s_rd_req, s_wr_req, e_rd_req, d_wr_req}), 32'd0);
    post("abort_flag", 32'({msg_valid, msg_invalid, aborted}), 32'b001);
    @(negedge clk);
    post("abort_busy", 32'(busy), 32'd0);
    stray_rd = 1'b1;
    @(negedge clk);
    stray_rd = 1'b0;
    @(negedge clk);
    post("abort_stray_state", 32'(fsm_state), 32'(IDLE));
    post("abort_stray_busy", 32'(busy), 32'd0);
    exp_s = s_init;
    check_s("abort_s");
    post("abort_d0", 32'(d_ram[0]), 32'h00);

    // msg_len=0 means a full 32-byte message; then a 1-byte follow-up run.
    rand_perm();
    for (int n = 0; n < MSG_LEN; n++) e_rom[n] = 8'($urandom);
    run(0, 1'b0);
    wait_done("full");
    check_s("full_s");
    craft_e(1, -1);
    run(1, 1'b1);
    post("rerun_flags_clear", 32'({msg_valid, msg_invalid, aborted}), 32'd0);
    wait_done("rerun");
    check_s("rerun_s");

    // Randomized runs; a stray start mid-run must be ignored.
    for (int r = 0; r < 6; r++) begin
      rand_perm();
      L = int'($urandom_range(10, 1));
      mode = r % 3;
      if (mode == 0) begin
        for (int n = 0; n < MSG_LEN; n++) e_rom[n] = 8'($urandom);
        chk = 1'($urandom);
      end else begin
        craft_e(L, (mode == 2) ? int'($urandom_range(L - 1, 0)) : -1);
        chk = 1'b1;
      end
      run(L, chk);
      repeat (2) @(negedge clk);
      start = 1'b1; msg_len = 6'd1; check_en = ~chk;
      @(negedge clk);
      start = 1'b0;
      wait_done("rand");
      check_s("rand_s");
    end

    // Asynchronous reset during WR_SJ of byte 0, then a normal run.
    set_identity();
    run(3, 1'b0);
    repeat (7) @(negedge clk);
    nreset = 1'b0;
    d_q.delete();
    done_q.delete();
    #1;
    check_outputs_zero("midreset");
    @(negedge clk);
    nreset = 1'b1;
    for (int n = 0; n < MSG_LEN; n++) e_rom[n] = 8'($urandom);
    run(4, 1'b0);
    wait_done("after_reset");
    check_s("after_reset_s");

    @(negedge clk);
    post("d_q_empty", 32'(d_q.size()), 32'd0);
    post("done_q_empty", 32'(done_q.size()), 32'd0);
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard time limit so the bench can never hang.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
